grf_wb_demux: RTL and testbench
===============================

Name: grf_wb_demux

Overview:
- 32-entry general register file for the single-cycle MIPS datapath.
- The write path works as the reverse of the datapath selectors: one write-back value plus a 5-bit address is decoded into a one-hot write strobe for exactly one register. Two read ports select register contents out.
- Sits between the write-back select logic and the ALU/comparator operand inputs.
- Also emits a registered write-back trace record for the team's grading log.

Parameters:
- WIDTH, 32, data width of each register and of all data ports.
- DEPTH_LOG2, 5, address width; register count is 2**DEPTH_LOG2.
- BYPASS, 1, when 1 a read of the register being written this cycle returns WD (write-through); when 0 it returns the stored value.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- A1  input  DEPTH_LOG2  read port 1 address.
- A2  input  DEPTH_LOG2  read port 2 address.
- RD1  output  WIDTH  read port 1 data (combinational).
- RD2  output  WIDTH  read port 2 data (combinational).
- WE  input  1  write enable.
- A3  input  DEPTH_LOG2  write address.
- WD  input  WIDTH  write data.
- PC  input  32  PC of the instruction writing back; used only for the trace record.
- wb_valid  output  1  trace: a real write committed last edge.
- wb_addr  output  DEPTH_LOG2  trace: register written.
- wb_data  output  WIDTH  trace: value written.
- wb_pc  output  32  trace: PC of the writing instruction.
- wr_onehot  output  2**DEPTH_LOG2  current decoded write strobe (combinational, debug).

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: all registers go to 0; wb_valid, wb_addr, wb_data and wb_pc go to 0. Reset takes priority over any write in the same cycle.
- Write decode:
  - wr_onehot[i] = WE & (A3 == i) & (i != 0). At most one bit is set.
  - wr_onehot is all-zero when WE=0 or A3=0.
- Register update: on the rising edge, if wr_onehot[i] then reg[i] <= WD. All other registers hold.
- Register 0: hardwired 0. Never written, always reads 0, with or without bypass.
- Read, combinational (RDn for port n = 1, 2):
  - If An == 0: RDn = 0.
  - Else if BYPASS=1 and WE=1 and A3 == An: RDn = WD.
  - Else: RDn = reg[An].
- Both read ports may address the same register, including the one being written. Both return the same value.
- Trace record, registered, updated every edge when reset is low:
  - wb_valid <= WE & (A3 != 0).
  - wb_addr, wb_data and wb_pc load A3, WD and PC only when the new wb_valid is 1; otherwise they hold their previous values.
  - A record is therefore visible exactly one cycle after the committing edge. Consecutive writes produce back-to-back valid records.
- Latency:
  - Write: visible to reads the cycle after the edge, or the same cycle via bypass.
  - Trace: 1 cycle.
- Reset mid-stream: a write presented during the reset cycle is discarded, and no trace record is produced for it.
- X-safety: any A1/A2/A3 value within DEPTH_LOG2 bits is legal. There is no out-of-range case.

Test Plan:
- Reset, then read all 32 addresses on both ports -> every RD1/RD2 = 0x00000000; wb_valid=0.
- WE=1, A3=8, WD=0x12345678, PC=0x00003000 for one edge; then A1=8 -> RD1=0x12345678. Next cycle: wb_valid=1, wb_addr=8, wb_data=0x12345678, wb_pc=0x00003000.
- WE=1, A3=0, WD=0xFFFFFFFF -> wr_onehot=0. Then A1=0 -> RD1=0. Next cycle: wb_valid=0 and the trace fields hold their prior values.
- BYPASS=1: reg 9 = 0x1. Drive WE=1, A3=9, WD=0xABCD, A1=A2=9 in the same cycle -> RD1=RD2=0xABCD before the edge. With BYPASS=0 -> RD1=RD2=0x1 before the edge, 0xABCD after.
- Write 0x5 to reg 31, then assert reset together with WE=1, A3=31, WD=0x7 -> after the edge RD1(31)=0 and wb_valid=0.
- Sweep A3=1..31 with WD=A3*0x11 on consecutive edges -> wr_onehot is one-hot with bit A3 set each cycle. Final read of every register i returns i*0x11, and the trace shows 31 consecutive valid records.

Source files
------------

// File: rtl/grf_wb_demux_if.sv
// Bus bundle for the register file: two read ports, one write port, the
// write-back trace record and the decoded write strobe.
interface grf_wb_demux_if #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5
);
  logic [DEPTH_LOG2-1:0]    A1;
  logic [DEPTH_LOG2-1:0]    A2;
  logic [WIDTH-1:0]         RD1;
  logic [WIDTH-1:0]         RD2;
  logic                     WE;
  logic [DEPTH_LOG2-1:0]    A3;
  logic [WIDTH-1:0]         WD;
  logic [31:0]              PC;
  logic                     wb_valid;
  logic [DEPTH_LOG2-1:0]    wb_addr;
  logic [WIDTH-1:0]         wb_data;
  logic [31:0]              wb_pc;
  logic [2**DEPTH_LOG2-1:0] wr_onehot;

  // Datapath side: drives addresses and write-back data, consumes results.
  modport master (
    output A1, A2, WE, A3, WD, PC,
    input  RD1, RD2, wb_valid, wb_addr, wb_data, wb_pc, wr_onehot
  );

  // Register file side.
  modport slave (
    input  A1, A2, WE, A3, WD, PC,
    output RD1, RD2, wb_valid, wb_addr, wb_data, wb_pc, wr_onehot
  );
endinterface

// File: rtl/grf_wb_demux.sv
// 32-entry MIPS general register file. The write-back value is demultiplexed
// onto a one-hot strobe; two combinational read ports with optional
// write-through; a registered trace record of each committed write.
module grf_wb_demux #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 5,
  parameter bit BYPASS     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  grf_wb_demux_if.slave     bus
);
  localparam int DEPTH = 2**DEPTH_LOG2;

  logic [WIDTH-1:0]      r_regs [DEPTH];
  logic [DEPTH-1:0]      w_onehot;
  logic                  w_commit;
  logic [WIDTH-1:0]      w_rd1;
  logic [WIDTH-1:0]      w_rd2;

  logic                  r_wb_valid;
  logic [DEPTH_LOG2-1:0] r_wb_addr;
  logic [WIDTH-1:0]      r_wb_data;
  logic [31:0]           r_wb_pc;

  // Decode WE/A3 into a one-hot strobe; entry 0 is never strobed.
  always_comb begin
    w_onehot = '0;
    for (int i = 1; i < DEPTH; i++) begin
      w_onehot[i] = bus.WE && (bus.A3 == DEPTH_LOG2'(i));
    end
  end

  assign w_commit = |w_onehot;

  // Register array update; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (w_onehot[i]) begin
          r_regs[i] <= bus.WD;
        end
      end
    end
  end

  // Read port 1: zero register, then write-through, then stored value.
  always_comb begin
    w_rd1 = r_regs[bus.A1];
    if (bus.A1 == '0) begin
      w_rd1 = '0;
    end else if (BYPASS && bus.WE && (bus.A3 == bus.A1)) begin
      w_rd1 = bus.WD;
    end
  end

  // Read port 2: same selection as port 1.
  always_comb begin
    w_rd2 = r_regs[bus.A2];
    if (bus.A2 == '0) begin
      w_rd2 = '0;
    end else if (BYPASS && bus.WE && (bus.A3 == bus.A2)) begin
      w_rd2 = bus.WD;
    end
  end

  // Trace record: valid pulses per committed write, fields hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
      r_wb_data  <= '0;
      r_wb_pc    <= '0;
    end else begin
      r_wb_valid <= w_commit;
      if (w_commit) begin
        r_wb_addr <= bus.A3;
        r_wb_data <= bus.WD;
        r_wb_pc   <= bus.PC;
      end
    end
  end

  assign bus.RD1       = w_rd1;
  assign bus.RD2       = w_rd2;
  assign bus.wr_onehot = w_onehot;
  assign bus.wb_valid  = r_wb_valid;
  assign bus.wb_addr   = r_wb_addr;
  assign bus.wb_data   = r_wb_data;
  assign bus.wb_pc     = r_wb_pc;
endmodule

// File: tb/tb_grf_wb_demux.sv
// Randomized and directed bench for grf_wb_demux. Two instances (write-through
// on and off) see identical stimulus and are compared with a behavioural model.
module tb_grf_wb_demux;
  logic clk;
  logic reset;

  grf_wb_demux_if #(.WIDTH(32), .DEPTH_LOG2(5)) if_byp ();
  grf_wb_demux_if #(.WIDTH(32), .DEPTH_LOG2(5)) if_nob ();

  assign if_nob.A1 = if_byp.A1;
  assign if_nob.A2 = if_byp.A2;
  assign if_nob.WE = if_byp.WE;
  assign if_nob.A3 = if_byp.A3;
  assign if_nob.WD = if_byp.WD;
  assign if_nob.PC = if_byp.PC;

  grf_wb_demux #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1'b1)) u_byp (
    .clk   (clk),
    .reset (reset),
    .bus   (if_byp)
  );

  grf_wb_demux #(.WIDTH(32), .DEPTH_LOG2(5), .BYPASS(1'b0)) u_nob (
    .clk   (clk),
    .reset (reset),
    .bus   (if_nob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference state: register contents and the last trace record.
  logic [31:0] mdl [32];
  logic        t_valid;
  logic [4:0]  t_addr;
  logic [31:0] t_data;
  logic [31:0] t_pc;
  int          n_chk;
  int          n_pass;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp,
                                           input logic we, input logic [4:0] a3,
                                           input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (byp && we && a3 == a) return wd;
    return mdl[a];
  endfunction

  // One clock: apply inputs, check combinational outputs, clock, check trace.
  task automatic step(input logic rst_i, input logic we, input logic [4:0] a1,
                      input logic [4:0] a2, input logic [4:0] a3,
                      input logic [31:0] wd, input logic [31:0] pc);
    logic [31:0] oh;
    reset     = rst_i;
    if_byp.WE = we;
    if_byp.A1 = a1;
    if_byp.A2 = a2;
    if_byp.A3 = a3;
    if_byp.WD = wd;
    if_byp.PC = pc;
    #1;
    oh = (we && a3 != 5'd0) ? (32'd1 << a3) : 32'd0;
    chk("onehot",     {32'd0, if_byp.wr_onehot}, {32'd0, oh});
    chk("rd1_byp",    {32'd0, if_byp.RD1}, {32'd0, exp_read(a1, 1'b1, we, a3, wd)});
    chk("rd2_byp",    {32'd0, if_byp.RD2}, {32'd0, exp_read(a2, 1'b1, we, a3, wd)});
    chk("rd1_nobyp",  {32'd0, if_nob.RD1}, {32'd0, exp_read(a1, 1'b0, we, a3, wd)});
    chk("rd2_nobyp",  {32'd0, if_nob.RD2}, {32'd0, exp_read(a2, 1'b0, we, a3, wd)});
    @(posedge clk);
    if (rst_i) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      t_valid = 1'b0;
      t_addr  = 5'd0;
      t_data  = 32'd0;
      t_pc    = 32'd0;
    end else if (we && a3 != 5'd0) begin
      mdl[a3] = wd;
      t_valid = 1'b1;
      t_addr  = a3;
      t_data  = wd;
      t_pc    = pc;
    end else begin
      t_valid = 1'b0;
    end
    #1;
    chk("wb_valid", {63'd0, if_byp.wb_valid}, {63'd0, t_valid});
    chk("wb_addr",  {59'd0, if_byp.wb_addr},  {59'd0, t_addr});
    chk("wb_data",  {32'd0, if_byp.wb_data},  {32'd0, t_data});
    chk("wb_pc",    {32'd0, if_byp.wb_pc},    {32'd0, t_pc});
    chk("wb_valid_nobyp", {63'd0, if_nob.wb_valid}, {63'd0, t_valid});
  endtask

  initial begin
    int n_valid;
    n_chk  = 0;
    n_pass = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'hDEAD_BEEF;
    t_valid = 1'b0; t_addr = '0; t_data = '0; t_pc = '0;

    // Reset, then read every address on both ports.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'd0, 32'd0);
      chk("reset_read_model", {32'd0, if_byp.RD1}, 64'd0);
    end

    // Single write to reg 8 with trace, then readback.
    step(1'b0, 1'b1, 5'd8, 5'd0, 5'd8, 32'h1234_5678, 32'h0000_3000);
    step(1'b0, 1'b0, 5'd8, 5'd8, 5'd0, 32'd0, 32'd0);
    chk("rd1_reg8", {32'd0, if_nob.RD1}, 64'h1234_5678);

    // Write to reg 0 is dropped; trace fields hold.
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
    step(1'b0, 1'b0, 5'd0, 5'd8, 5'd0, 32'd0, 32'd0);

    // Write-through vs stored value on reg 9.
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h1, 32'h0000_3008);
    step(1'b0, 1'b1, 5'd9, 5'd9, 5'd9, 32'hABCD, 32'h0000_300C);
    step(1'b0, 1'b0, 5'd9, 5'd9, 5'd0, 32'd0, 32'd0);

    // Reset beats a same-cycle write to reg 31.
    step(1'b0, 1'b1, 5'd31, 5'd0, 5'd31, 32'h5, 32'h0000_3010);
    step(1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 32'h7, 32'h0000_3014);
    step(1'b0, 1'b0, 5'd31, 5'd31, 5'd0, 32'd0, 32'd0);
    chk("rd1_reg31_after_reset", {32'd0, if_nob.RD1}, 64'd0);

    // Sweep every writable register on consecutive edges.
    n_valid = 0;
    for (int i = 1; i < 32; i++) begin
      step(1'b0, 1'b1, 5'(i), 5'(i - 1), 5'(i), 32'(i * 32'h11), 32'h0000_4000 + 32'(4 * i));
      if (if_byp.wb_valid) n_valid++;
    end
    chk("sweep_valid_count", 64'(n_valid), 64'd31);
    for (int i = 0; i < 32; i++) begin
      step(1'b0, 1'b0, 5'(i), 5'(i), 5'd0, 32'd0, 32'd0);
      chk("sweep_readback", {32'd0, if_nob.RD1}, {32'd0, 32'(i * 32'h11)});
    end

    // Randomized traffic with occasional reset.
    for (int n = 0; n < 400; n++) begin
      logic [4:0] a1, a2, a3;
      logic       we, rs;
      a3 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? a3 : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 3) != 0);
      rs = 1'($urandom_range(0, 49) == 0);
      step(rs, we, a1, a2, a3, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
